// File: rtl/crc_result_sched.sv
// Serialises parallel per-lane CRC results into one valid/ready stream in packet order,
// with a two-batch buffer and overflow statistics.
module crc_result_sched #(
    parameter int PKT_NUM = 8,
    parameter int LANE_W  = 3,
    parameter int SEQ_W   = 16,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PKT_NUM-1:0]     crc_en_in,
    input  logic [32*PKT_NUM-1:0]  crc_in,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [31:0]            m_crc,
    output logic [LANE_W-1:0]      m_lane,
    output logic [SEQ_W-1:0]       m_seq,
    input  logic                   clr_stats,
    output logic                   ovf_sticky,
    output logic [CNT_W-1:0]       drop_cnt
);

    logic [PKT_NUM-1:0]    mask_q [2];
    logic [32*PKT_NUM-1:0] crc_q  [2];
    logic                  rptr_q, wptr_q;
    logic [1:0]            cnt_q, cnt_d;
    logic [SEQ_W-1:0]      seq_q;
    logic                  ovf_q, ovf_d;
    logic [CNT_W-1:0]      drop_q, drop_d;

    logic [PKT_NUM-1:0]    head_mask, sel_bit;
    logic [LANE_W-1:0]     sel_lane;
    logic [31:0]           sel_crc;
    logic                  valid, hs, last, pop, cand, push, drop;
    logic [CNT_W-1:0]      pc, base;
    logic [CNT_W:0]        sum;

    // Lowest pending lane of the head batch wins; loop runs high-to-low so the last hit is the lowest.
    always_comb begin
        head_mask = mask_q[rptr_q];
        sel_lane  = '0;
        sel_crc   = '0;
        for (int i = PKT_NUM - 1; i >= 0; i--) begin
            if (head_mask[i]) begin
                sel_lane = LANE_W'(i);
                sel_crc  = crc_q[rptr_q][32*i +: 32];
            end
        end
    end

    assign sel_bit = PKT_NUM'(1) << sel_lane;
    assign valid   = (cnt_q != 2'd0);
    assign hs      = valid & m_ready;
    assign last    = ((head_mask & ~sel_bit) == '0);
    assign pop     = hs & last;
    assign cand    = |crc_en_in;
    assign push    = cand & ((cnt_q != 2'd2) | pop);
    assign drop    = cand & ~push;
    assign cnt_d   = cnt_q + 2'(push) - 2'(pop);

    always_comb begin
        pc = '0;
        for (int i = 0; i < PKT_NUM; i++) pc = pc + CNT_W'(crc_en_in[i]);
        // A drop coincident with clr_stats restarts the count from that drop rather than losing it.
        base = clr_stats ? '0 : drop_q;
        sum  = {1'b0, base} + {1'b0, pc};
        drop_d = drop_q;
        ovf_d  = ovf_q;
        if (drop) begin
            drop_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
            ovf_d  = 1'b1;
        end else if (clr_stats) begin
            drop_d = '0;
            ovf_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q[0] <= '0;
            mask_q[1] <= '0;
            rptr_q    <= 1'b0;
            wptr_q    <= 1'b0;
            cnt_q     <= 2'd0;
            seq_q     <= '0;
            ovf_q     <= 1'b0;
            drop_q    <= '0;
        end else begin
            if (hs) mask_q[rptr_q] <= head_mask & ~sel_bit;
            // When full, wptr aliases rptr; the push write must land after the retire clear.
            if (push) mask_q[wptr_q] <= crc_en_in;
            if (push) wptr_q <= ~wptr_q;
            if (pop)  rptr_q <= ~rptr_q;
            if (hs)   seq_q  <= seq_q + SEQ_W'(1);
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) crc_q[wptr_q] <= crc_in;
    end

    assign m_valid    = valid;
    assign m_lane     = valid ? sel_lane : '0;
    assign m_crc      = valid ? sel_crc : '0;
    assign m_seq      = seq_q;
    assign ovf_sticky = ovf_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_crc_result_sched.sv
// Scoreboard bench for crc_result_sched: directed pushes queue expected results,
// an independent monitor checks every handshake.
module tb_crc_result_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   crc_en_in;
    logic [255:0] crc_in;
    logic         m_valid, m_ready;
    logic [31:0]  m_crc;
    logic [2:0]   m_lane;
    logic [15:0]  m_seq;
    logic         clr_stats, ovf_sticky;
    logic [15:0]  drop_cnt;

    crc_result_sched dut (
        .clk(clk), .rst(rst), .crc_en_in(crc_en_in), .crc_in(crc_in),
        .m_valid(m_valid), .m_ready(m_ready), .m_crc(m_crc), .m_lane(m_lane),
        .m_seq(m_seq), .clr_stats(clr_stats), .ovf_sticky(ovf_sticky), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] crc; logic [2:0] lane; } exp_t;
    exp_t q[$];
    int   n_chk = 0, n_fail = 0;
    int   exp_seq = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] mk(input int tag);
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = {16'hC0DE, 8'(tag), 8'(i)};
        return v;
    endfunction

    // Monitor: every handshake must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 32'(m_lane), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("mon_lane", 32'(m_lane), 32'(e.lane));
                chk("mon_crc", m_crc, e.crc);
                chk("mon_seq", 32'(m_seq), 32'(exp_seq[15:0]));
                exp_seq++;
            end
        end
    end

    task automatic drive(input logic [7:0] en, input logic [255:0] v, input bit acc);
        crc_en_in = en;
        crc_in    = v;
        if (acc)
            for (int i = 0; i < 8; i++)
                if (en[i]) q.push_back('{crc: v[32*i +: 32], lane: 3'(i)});
        @(posedge clk); #1;
        crc_en_in = '0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 60 && q.size() != 0; k++) @(posedge clk);
        #1;
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [255:0] v;
        rst = 1'b1; crc_en_in = '0; crc_in = '0; m_ready = 1'b0; clr_stats = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_seq", 32'(m_seq), 32'd0);
        chk("rst_ovf", 32'(ovf_sticky), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_lane", 32'(m_lane), 32'd0);
        chk("rst_crc", m_crc, 32'd0);
        @(posedge clk); #1;

        // Single result, one-cycle latency
        m_ready = 1'b1;
        v = mk(1); v[95:64] = 32'hCBF43926;
        drive(8'h04, v, 1'b1);
        @(negedge clk);
        chk("t1_valid", 32'(m_valid), 32'd1);
        chk("t1_lane", 32'(m_lane), 32'd2);
        chk("t1_crc", m_crc, 32'hCBF43926);
        chk("t1_seq", 32'(m_seq), 32'd0);
        @(negedge clk);
        chk("t1_idle", 32'(m_valid), 32'd0);
        @(posedge clk); #1;

        // Multi-lane ordering across two input cycles
        drive(8'h83, mk(2), 1'b1);
        drive(8'h04, mk(3), 1'b1);
        wait_drain();
        @(negedge clk);
        chk("t2_seq", 32'(m_seq), 32'd5);
        @(posedge clk); #1;

        // Backpressure holds the output stable
        m_ready = 1'b0;
        drive(8'h04, mk(4), 1'b1);
        repeat (5) begin
            @(negedge clk);
            chk("t3_valid", 32'(m_valid), 32'd1);
            chk("t3_lane", 32'(m_lane), 32'd2);
            chk("t3_crc", m_crc, 32'hC0DE_0402);
            chk("t3_seq", 32'(m_seq), 32'd5);
        end
        @(posedge clk); #1 m_ready = 1'b1;
        @(posedge clk); #1 m_ready = 1'b0;
        @(negedge clk);
        chk("t3_after", 32'(m_valid), 32'd0);
        chk("t3_seq6", 32'(m_seq), 32'd6);
        @(posedge clk); #1;

        // Overflow: third batch dropped whole
        drive(8'hFF, mk(5), 1'b1);
        drive(8'h0F, mk(6), 1'b1);
        drive(8'h03, mk(7), 1'b0);
        @(negedge clk);
        chk("t4_ovf", 32'(ovf_sticky), 32'd1);
        chk("t4_drop", 32'(drop_cnt), 32'd2);
        @(posedge clk); #1 m_ready = 1'b1;
        wait_drain();
        @(negedge clk);
        chk("t4_idle", 32'(m_valid), 32'd0);
        chk("t4_seq", 32'(m_seq), 32'd18);
        @(posedge clk); #1;

        // Full FIFO with simultaneous pop accepts the push
        m_ready = 1'b0;
        drive(8'h01, mk(8), 1'b1);
        drive(8'h03, mk(9), 1'b1);
        m_ready = 1'b1;
        drive(8'h01, mk(10), 1'b1);
        m_ready = 1'b0;
        @(negedge clk);
        chk("t5_drop", 32'(drop_cnt), 32'd2);
        @(posedge clk); #1;
        drive(8'h01, mk(11), 1'b0);
        @(negedge clk);
        chk("t5_full", 32'(drop_cnt), 32'd3);
        @(posedge clk); #1 m_ready = 1'b1;
        wait_drain();

        // Reset mid-drain discards pending results
        m_ready = 1'b0;
        drive(8'h3F, mk(12), 1'b1);
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        exp_seq = 0;
        @(negedge clk);
        chk("t6_valid", 32'(m_valid), 32'd0);
        chk("t6_seq", 32'(m_seq), 32'd0);
        chk("t6_drop", 32'(drop_cnt), 32'd0);
        chk("t6_ovf", 32'(ovf_sticky), 32'd0);
        @(posedge clk); #1;

        // clr_stats coincident with a drop keeps the new drop
        drive(8'h01, mk(13), 1'b1);
        drive(8'h01, mk(14), 1'b1);
        drive(8'h03, mk(15), 1'b0);
        @(negedge clk);
        chk("t7_pre", 32'(drop_cnt), 32'd2);
        @(posedge clk); #1;
        clr_stats = 1'b1;
        drive(8'h07, mk(16), 1'b0);
        clr_stats = 1'b0;
        @(negedge clk);
        chk("t7_drop", 32'(drop_cnt), 32'd3);
        chk("t7_ovf", 32'(ovf_sticky), 32'd1);
        @(posedge clk); #1 clr_stats = 1'b1;
        @(posedge clk); #1 clr_stats = 1'b0;
        @(negedge clk);
        chk("t7_clr_drop", 32'(drop_cnt), 32'd0);
        chk("t7_clr_ovf", 32'(ovf_sticky), 32'd0);
        @(posedge clk); #1 m_ready = 1'b1;
        wait_drain();
        @(negedge clk);
        chk("t7_seq", 32'(m_seq), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
